// File: rtl/serial_word_receiver.sv
// serial_word_receiver
//   Receiving end of the shift-register serial path. It samples S_OUT with the
//   same ENB/DIR/MODO qualifiers that drive the shift register, so it stays
//   bit-aligned with that register. It reassembles WIDTH-bit words and hands
//   them off through a VALID/READY holding register. A sticky OVERFLOW flag
//   records any completed word that was dropped.
//
// Ports
//   CLK       rising-edge clock
//   RESET_N   asynchronous active-low reset
//   ENB       sample enable (the READY handshake still runs when ENB=0)
//   DIR       0: MSB arrives first, 1: LSB arrives first
//   MODO      00 sample, 01 hold, 10 resync (parallel load), 11 clear
//   S_OUT     serial bit from the shift register
//   READY     consumer accepts WORD when READY and VALID are both high
//   WORD      last completed word
//   VALID     WORD holds an unconsumed word
//   OVERFLOW  sticky: a completed word was dropped
//   BIT_CNT   bits collected toward the current word
module serial_word_receiver #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             ENB,
    input  logic             DIR,
    input  logic [1:0]       MODO,
    input  logic             S_OUT,
    input  logic             READY,
    output logic [WIDTH-1:0] WORD,
    output logic             VALID,
    output logic             OVERFLOW,
    output logic [CNT_W-1:0] BIT_CNT
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             dir_q;

    logic             dir_flip;
    logic             complete;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;

    // A direction change throws away the partial word. The shift therefore
    // starts from an empty accumulator, and the current bit becomes bit 1.
    assign dir_flip = (DIR != dir_q);
    assign base     = dir_flip ? '0 : acc_q;
    assign shifted  = DIR ? {S_OUT, base[WIDTH-1:1]} : {base[WIDTH-2:0], S_OUT};

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        complete = 1'b0;

        if (valid_q && READY) begin
            valid_d = 1'b0;
        end

        if (ENB) begin
            case (MODO)
                2'b00: begin
                    if (dir_flip) begin
                        acc_d = shifted;
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q == LAST_BIT) begin
                        complete = 1'b1;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        acc_d = shifted;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                2'b10: begin
                    acc_d = '0;
                    cnt_d = '0;
                end
                2'b11: begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
                default: begin
                end
            endcase
        end

        // A word accepted on this same edge frees the holding register, so
        // only an unaccepted word that is still pending forces a drop.
        if (complete) begin
            if (!valid_q || READY) begin
                word_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            dir_q   <= DIR;
        end
    end

    assign WORD     = word_q;
    assign VALID    = valid_q;
    assign OVERFLOW = ovf_q;
    assign BIT_CNT  = cnt_q;

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Receiving end of the shift-register serial path: samples the register's S_OUT bit stream and reassembles it into WIDTH-bit parallel words.
- Uses the same ENB/DIR/MODO control qualifiers that drive the shift register, so it stays bit-aligned with it.
- Delivers completed words through a VALID/READY holding register with a sticky overflow flag.
- Sits beside the shift register as its downstream consumer.

Parameters:
- WIDTH, 4, word length in bits; also the number of S_OUT samples per word.
- CNT_W, 2, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- ENB  input  1  sample enable; when 0, no state changes except the READY handshake.
- DIR  input  1  shift direction. 0 = left shift, S_OUT carries the MSB first. 1 = right shift, S_OUT carries the LSB first.
- MODO  input  2  mode: 00 shift/sample, 10 parallel load (resync), 11 clear, 01 hold.
- S_OUT  input  1  serial bit from the shift register.
- READY  input  1  consumer accepts WORD when READY and VALID are both 1 at an edge.
- WORD  output  WIDTH  last completed word.
- VALID  output  1  WORD holds an unconsumed word.
- OVERFLOW  output  1  sticky; a completed word was dropped.
- BIT_CNT  output  CNT_W  number of bits collected toward the current word.

Behaviour:
- Reset (RESET_N=0, async, any time including mid-word): accumulator, WORD, BIT_CNT = 0; VALID = 0; OVERFLOW = 0. All outputs are 0 while reset is held.
- Sampling: an edge is a sample edge only when ENB=1 and MODO=00.
  - DIR=0: acc <= {acc[WIDTH-2:0], S_OUT} (first bit ends up as MSB).
  - DIR=1: acc <= {S_OUT, acc[WIDTH-1:1]} (first bit ends up as LSB).
  - BIT_CNT increments on each sample edge.
- Word completion: on the sample edge that takes bit number WIDTH:
  - The assembled word, including the bit sampled at that edge, is the completed word.
  - BIT_CNT wraps to 0 and the accumulator is reused.
  - Latency: WORD/VALID are visible right after that same edge; there is no extra cycle.
- Delivery at a completion edge:
  - If VALID=0, or VALID=1 and READY=1: WORD <= completed word, VALID <= 1.
  - If VALID=1 and READY=0: the completed word is dropped, WORD is unchanged, OVERFLOW <= 1.
- Handshake:
  - VALID=1 and READY=1 at an edge with no completion: VALID <= 0; WORD holds its value.
  - The handshake is evaluated regardless of ENB and MODO.
- MODO=10 (parallel load) with ENB=1: BIT_CNT <= 0 and acc <= 0, so the receiver resyncs to the newly loaded register contents. WORD, VALID and OVERFLOW are unaffected.
- MODO=11 with ENB=1: BIT_CNT <= 0, acc <= 0, OVERFLOW <= 0; VALID/WORD are unaffected.
- MODO=01, or ENB=0: acc and BIT_CNT hold.
- DIR change mid-word: DIR is registered. On a sample edge where DIR differs from its value at the previous edge:
  - The partial word is discarded.
  - The bit sampled at that edge becomes bit 1 of a new word (BIT_CNT <= 1).
- OVERFLOW clears only on reset or MODO=11; it never self-clears.
- All arithmetic is unsigned. BIT_CNT never exceeds WIDTH-1 at an observable point.

Test Plan:
1. Reset: assert RESET_N=0 asynchronously mid-word with BIT_CNT=2, VALID=1 -> WORD=0000, VALID=0, OVERFLOW=0, BIT_CNT=0 immediately, with no clock edge needed.
2. MSB-first: ENB=1, MODO=00, DIR=0, READY=0, S_OUT=1,0,1,1 on 4 edges -> after 4th edge WORD=1011, VALID=1, BIT_CNT=0.
3. LSB-first plus enable gating: DIR=1, stream 1,0 then ENB=0 for 2 edges then 1,1 -> BIT_CNT holds at 2 during ENB=0; final WORD=1101, VALID=1.
4. Overflow: DIR=0, READY=0, stream 0001 then 0110 -> WORD=0001, VALID=1, OVERFLOW=1. Then READY=1 for one edge -> VALID=0. Then MODO=11 -> OVERFLOW=0.
5. Simultaneous accept and completion: VALID=1 with WORD=0001, READY=1 on the edge completing 1110 -> WORD=1110, VALID=1, OVERFLOW=0.
6. Resync and DIR change:
   - Two bits in, then MODO=10 for one edge -> BIT_CNT=0; the next 4 bits 1,0,0,1 give WORD=1001.
   - Separately, flip DIR after 2 bits -> BIT_CNT=1 after the flip edge, and the earlier bits are absent from the next WORD.
